// File: rtl/third_mode_countdown_event_module_pkg.sv
// Shared constants for the hurricane-mode countdown: widths, mode codes,
// countdown FSM state encoding and timing defaults.
package third_mode_countdown_event_module_pkg;

    localparam int MAX_WIDTH_DEF      = 16;
    localparam int MODE_WIDTH_DEF     = 3;
    localparam int COUNTER_1SEC_DEF   = 49_999_999;
    localparam int THIRD_COUNTDOWN_SEC = 60;

    // Mode codes shared with the mode controller.
    localparam int STANDBY_MODE = 0;
    localparam int FIRST_MODE   = 1;
    localparam int SECOND_MODE  = 2;
    localparam int THIRD_MODE   = 3;

    // Countdown FSM states.
    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_REQ  = 2'd2
    } cd_state_t;

endpackage

// File: rtl/third_mode_countdown_event_module_tick.sv
// One-second tick generator: counts clock cycles while enabled and emits a
// single-cycle tick when the counter sits at its terminal value.
module one_sec_tick_gen #(
    parameter int WIDTH    = 16,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt;

    // A clear suppresses the tick so a same-cycle abort wins over it.
    assign tick = enable && !clear && (cnt == TERM);

    // Cycle counter: clear has priority, wraps to 0 on the terminal value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == TERM) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/third_mode_countdown_event_module.sv
// Hurricane (THIRD) mode countdown. Counts seconds down from a preset while
// the mode is applied, accumulates total hurricane time, locks the mode out
// after one use per power-on session, and on expiry asks the mode controller
// to drop to SECOND mode.
// Handshake: req_valid rises with req_mode=SECOND and both stay stable until
// a cycle where req_ack=1 is seen (request consumed), or the request is
// withdrawn because the mode left THIRD or power_off was pulsed.
module third_mode_countdown_event_module
    import third_mode_countdown_event_module_pkg::*;
#(
    parameter int MAX_WIDTH         = MAX_WIDTH_DEF,
    parameter int MODE_WIDTH        = MODE_WIDTH_DEF,
    parameter int COUNTER_1SEC      = COUNTER_1SEC_DEF,
    parameter int COUNTDOWN_SECONDS = THIRD_COUNTDOWN_SEC
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [MODE_WIDTH-1:0] current_mode,
    input  logic                  power_off,
    input  logic                  req_ack,
    output logic [MAX_WIDTH-1:0]  remaining_time,
    output logic [MAX_WIDTH-1:0]  total_running_time,
    output logic                  third_available,
    output logic                  req_valid,
    output logic [MODE_WIDTH-1:0] req_mode,
    output logic                  countdown_done
);

    localparam logic [MAX_WIDTH-1:0]  PRESET   = MAX_WIDTH'(COUNTDOWN_SECONDS);
    localparam logic [MODE_WIDTH-1:0] M_THIRD  = MODE_WIDTH'(THIRD_MODE);
    localparam logic [MODE_WIDTH-1:0] M_SECOND = MODE_WIDTH'(SECOND_MODE);
    localparam logic [MODE_WIDTH-1:0] M_STDBY  = MODE_WIDTH'(STANDBY_MODE);

    cd_state_t state, state_nxt;

    logic used, used_nxt;
    logic [MAX_WIDTH-1:0]  remaining_nxt, total_nxt;
    logic                  req_valid_nxt, done_nxt;
    logic [MODE_WIDTH-1:0] req_mode_nxt;

    logic is_third;
    logic tick;
    logic tick_clear;

    assign is_third   = (current_mode == M_THIRD);
    assign tick_clear = (state != CD_RUN) || !is_third || power_off;

    one_sec_tick_gen #(
        .WIDTH    (MAX_WIDTH),
        .TERMINAL (COUNTER_1SEC)
    ) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .enable (state == CD_RUN),
        .clear  (tick_clear),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= CD_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; power_off forces IDLE ahead of everything else.
    always_comb begin
        state_nxt = state;
        if (power_off) begin
            state_nxt = CD_IDLE;
        end else begin
            case (state)
                CD_IDLE: if (is_third && !used) state_nxt = CD_RUN;
                CD_RUN: begin
                    if (!is_third)                          state_nxt = CD_IDLE;
                    else if (tick && remaining_time == 1'b1) state_nxt = CD_REQ;
                end
                CD_REQ: if ((req_ack && req_valid) || !is_third) state_nxt = CD_IDLE;
                default: state_nxt = CD_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the session lockout flag.
    always_comb begin
        used_nxt      = used;
        remaining_nxt = remaining_time;
        total_nxt     = total_running_time;
        req_valid_nxt = req_valid;
        req_mode_nxt  = req_mode;
        done_nxt      = 1'b0;
        case (state)
            CD_IDLE: begin
                remaining_nxt = PRESET;
                if (is_third && !used) used_nxt = 1'b1;
            end
            CD_RUN: begin
                if (power_off || !is_third) begin
                    remaining_nxt = PRESET;
                end else if (tick) begin
                    remaining_nxt = remaining_time - 1'b1;
                    total_nxt     = total_running_time + 1'b1;
                    if (remaining_time == 1'b1) begin
                        done_nxt      = 1'b1;
                        req_valid_nxt = 1'b1;
                        req_mode_nxt  = M_SECOND;
                    end
                end
            end
            CD_REQ: begin
                remaining_nxt = '0;
                if (power_off || (req_ack && req_valid) || !is_third) begin
                    req_valid_nxt = 1'b0;
                    req_mode_nxt  = M_STDBY;
                end
            end
            default: remaining_nxt = PRESET;
        endcase
        if (power_off) used_nxt = 1'b0;
    end

    // Output and lockout registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            used               <= 1'b0;
            third_available    <= 1'b1;
            remaining_time     <= PRESET;
            total_running_time <= '0;
            req_valid          <= 1'b0;
            req_mode           <= M_STDBY;
            countdown_done     <= 1'b0;
        end else begin
            used               <= used_nxt;
            third_available    <= ~used_nxt;
            remaining_time     <= remaining_nxt;
            total_running_time <= total_nxt;
            req_valid          <= req_valid_nxt;
            req_mode           <= req_mode_nxt;
            countdown_done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_third_mode_countdown_event_module.sv
// Directed bench for the hurricane countdown with a 4-cycle second and a
// 3-second preset.
module tb_third_mode_countdown_event_module;

    localparam int MW = 16;
    localparam int DW = 3;
    localparam logic [DW-1:0] STDBY = 3'd0;
    localparam logic [DW-1:0] SECND = 3'd2;
    localparam logic [DW-1:0] THIRD = 3'd3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] current_mode = STDBY;
    logic          power_off = 1'b0;
    logic          req_ack = 1'b0;
    logic [MW-1:0] remaining_time;
    logic [MW-1:0] total_running_time;
    logic          third_available;
    logic          req_valid;
    logic [DW-1:0] req_mode;
    logic          countdown_done;

    int checks = 0;
    int errors = 0;
    int done_count;

    third_mode_countdown_event_module #(
        .MAX_WIDTH         (MW),
        .MODE_WIDTH        (DW),
        .COUNTER_1SEC      (3),
        .COUNTDOWN_SECONDS (3)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .current_mode       (current_mode),
        .power_off          (power_off),
        .req_ack            (req_ack),
        .remaining_time     (remaining_time),
        .total_running_time (total_running_time),
        .third_available    (third_available),
        .req_valid          (req_valid),
        .req_mode           (req_mode),
        .countdown_done     (countdown_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_power_off();
        power_off = 1'b1;
        @(negedge clk);
        power_off = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rstn is held low.
        cycles(3);
        check("rst_remaining", remaining_time, 3);
        check("rst_total", total_running_time, 0);
        check("rst_avail", third_available, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_mode", req_mode, STDBY);
        check("rst_done", countdown_done, 0);
        rstn = 1'b1;
        cycles(2);
        check("idle_remaining", remaining_time, 3);

        // Full countdown: ticks after edges 4, 8, 12 following entry.
        current_mode = THIRD;
        done_count = 0;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (countdown_done) done_count++;
            check("cd_remaining", remaining_time, (j < 4) ? 3 : (j < 8) ? 2 : (j < 12) ? 1 : 0);
            check("cd_done", countdown_done, (j == 12) ? 1 : 0);
            if (j == 0) check("cd_avail_cleared", third_available, 0);
        end
        check("cd_req_valid", req_valid, 1);
        check("cd_req_mode", req_mode, SECND);
        check("cd_total", total_running_time, 3);

        // Handshake: request holds without ack, drops after ack.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (countdown_done) done_count++;
            check("hs_hold_valid", req_valid, 1);
            check("hs_hold_mode", req_mode, SECND);
            check("hs_hold_remaining", remaining_time, 0);
        end
        check("cd_done_once", done_count, 1);
        req_ack = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        check("hs_valid_dropped", req_valid, 0);
        check("hs_state_idle", dut.state, 0);
        check("hs_avail", third_available, 0);
        cycles(1);
        check("hs_reload", remaining_time, 3);
        check("hs_locked_idle", dut.state, 0);

        // Re-arm, then abort after one tick.
        current_mode = STDBY;
        pulse_power_off();
        check("po_avail", third_available, 1);
        current_mode = THIRD;
        cycles(6);
        check("ab_pre_remaining", remaining_time, 2);
        check("ab_pre_total", total_running_time, 4);
        current_mode = STDBY;
        @(negedge clk);
        check("ab_remaining", remaining_time, 3);
        check("ab_total", total_running_time, 4);
        check("ab_req_valid", req_valid, 0);
        check("ab_avail", third_available, 0);

        // Lockout: THIRD again without power_off does nothing.
        current_mode = THIRD;
        cycles(8);
        check("lk_remaining", remaining_time, 3);
        check("lk_total", total_running_time, 4);
        check("lk_state", dut.state, 0);

        // power_off while THIRD is requested: stays IDLE this cycle, then runs.
        pulse_power_off();
        check("po2_avail", third_available, 1);
        check("po2_state", dut.state, 0);
        cycles(1);
        check("po2_run", dut.state, 1);
        cycles(4);
        check("po2_tick_remaining", remaining_time, 2);
        check("po2_tick_total", total_running_time, 5);
        // Abort on the same cycle as the next tick: the tick is lost.
        cycles(3);
        current_mode = STDBY;
        @(negedge clk);
        check("abt_remaining", remaining_time, 3);
        check("abt_total", total_running_time, 5);
        check("abt_done", countdown_done, 0);

        // Asynchronous reset between edges during RUN.
        pulse_power_off();
        current_mode = THIRD;
        cycles(5);
        check("ar_pre_remaining", remaining_time, 2);
        #2 rstn = 1'b0;
        #1;
        check("ar_remaining", remaining_time, 3);
        check("ar_total", total_running_time, 0);
        check("ar_avail", third_available, 1);
        check("ar_req_valid", req_valid, 0);
        check("ar_done", countdown_done, 0);
        check("ar_state", dut.state, 0);
        current_mode = STDBY;
        @(negedge clk);
        rstn = 1'b1;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
